// File: rtl/wave_field_streamer_if.sv
// Sample stream from the field readout engine to the host/DMA sink.
// The master drives one mesh sample per valid/ready handshake together with its framing flags.
interface wave_field_streamer_if #(
    parameter int MESH_X    = 8,
    parameter int MESH_Y    = 8,
    parameter int PSI_WIDTH = 16
);
    localparam int XW = $clog2(MESH_X);
    localparam int YW = $clog2(MESH_Y);

    logic                     out_valid;
    logic                     out_ready;
    logic [XW-1:0]            out_x;
    logic [YW-1:0]            out_y;
    // psi packed as {re, im}, both signed PSI_WIDTH-bit values
    logic [2*PSI_WIDTH-1:0]   out_psi;
    logic [PSI_WIDTH-1:0]     out_mag;
    logic                     out_sof;
    logic                     out_eol;
    logic                     out_eof;

    modport master (
        output out_valid, out_x, out_y, out_psi, out_mag, out_sof, out_eol, out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_x, out_y, out_psi, out_mag, out_sof, out_eol, out_eof,
        output out_ready
    );
endinterface

// File: rtl/wave_field_streamer.sv
// Field readout engine: on an accepted frame_done, walks the mesh read port in raster order,
// streams every sample with framing flags and reports the frame norm and peak magnitude.
module wave_field_streamer #(
    parameter int MESH_X    = 8,
    parameter int MESH_Y    = 8,
    parameter int PSI_WIDTH = 16,
    parameter int READ_LAT  = 1,
    localparam int XW = $clog2(MESH_X),
    localparam int YW = $clog2(MESH_Y),
    localparam int SW = PSI_WIDTH + XW + YW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_done_i,
    input  logic [7:0]             decim_i,
    output logic [XW-1:0]          read_x_o,
    output logic [YW-1:0]          read_y_o,
    input  logic [2*PSI_WIDTH-1:0] read_psi_i,
    input  logic [PSI_WIDTH-1:0]   read_magnitude_i,
    wave_field_streamer_if.master  sink,
    output logic                   hold_evolve_o,
    output logic                   norm_valid_o,
    output logic [SW-1:0]          norm_sum_o,
    output logic [PSI_WIDTH-1:0]   peak_mag_o,
    output logic [XW-1:0]          peak_x_o,
    output logic [YW-1:0]          peak_y_o,
    output logic [7:0]             overrun_cnt_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD, ST_DONE} state_t;

    localparam logic [2:0]    LAT_LD = 3'(READ_LAT);
    localparam logic [XW-1:0] X_LAST = XW'(MESH_X - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(MESH_Y - 1);

    state_t                 state_q, state_d;
    logic [7:0]             dcnt_q, dcnt_d;
    logic [2:0]             wait_q, wait_d;
    logic [XW-1:0]          rx_q, rx_d;
    logic [YW-1:0]          ry_q, ry_d;
    logic                   valid_q, valid_d;
    logic [XW-1:0]          ox_q, ox_d;
    logic [YW-1:0]          oy_q, oy_d;
    logic [2*PSI_WIDTH-1:0] psi_q, psi_d;
    logic [PSI_WIDTH-1:0]   mag_q, mag_d;
    logic                   sof_q, sof_d;
    logic                   eol_q, eol_d;
    logic                   eof_q, eof_d;
    logic [SW-1:0]          sum_q, sum_d;
    logic [PSI_WIDTH-1:0]   pk_mag_q, pk_mag_d;
    logic [XW-1:0]          pk_x_q, pk_x_d;
    logic [YW-1:0]          pk_y_q, pk_y_d;
    logic [7:0]             ovr_q, ovr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dcnt_q   <= '0;
            wait_q   <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            valid_q  <= 1'b0;
            ox_q     <= '0;
            oy_q     <= '0;
            psi_q    <= '0;
            mag_q    <= '0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            sum_q    <= '0;
            pk_mag_q <= '0;
            pk_x_q   <= '0;
            pk_y_q   <= '0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            wait_q   <= wait_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            valid_q  <= valid_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            psi_q    <= psi_d;
            mag_q    <= mag_d;
            sof_q    <= sof_d;
            eol_q    <= eol_d;
            eof_q    <= eof_d;
            sum_q    <= sum_d;
            pk_mag_q <= pk_mag_d;
            pk_x_q   <= pk_x_d;
            pk_y_q   <= pk_y_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        wait_d   = wait_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        valid_d  = valid_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        psi_d    = psi_q;
        mag_d    = mag_q;
        sof_d    = sof_q;
        eol_d    = eol_q;
        eof_d    = eof_q;
        sum_d    = sum_q;
        pk_mag_d = pk_mag_q;
        pk_x_d   = pk_x_q;
        pk_y_d   = pk_y_q;
        ovr_d    = ovr_q;

        // Any frame_done outside IDLE is lost; the decimation phase is left untouched.
        if (frame_done_i && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_done_i) begin
                    if (dcnt_q == 8'd0) begin
                        dcnt_d   = decim_i;
                        rx_d     = '0;
                        ry_d     = '0;
                        wait_d   = LAT_LD;
                        sum_d    = '0;
                        pk_mag_d = '0;
                        pk_x_d   = '0;
                        pk_y_d   = '0;
                        state_d  = ST_WAIT;
                    end else begin
                        dcnt_d = dcnt_q - 8'd1;
                    end
                end
            end
            ST_WAIT: begin
                wait_d = wait_q - 3'd1;
                if (wait_q <= 3'd1) begin
                    ox_d    = rx_q;
                    oy_d    = ry_q;
                    psi_d   = read_psi_i;
                    mag_d   = read_magnitude_i;
                    sof_d   = (rx_q == '0) && (ry_q == '0);
                    eol_d   = (rx_q == X_LAST);
                    eof_d   = (rx_q == X_LAST) && (ry_q == Y_LAST);
                    valid_d = 1'b1;
                    sum_d   = sum_q + SW'(read_magnitude_i);
                    // Strict compare keeps the first maximum in scan order.
                    if (read_magnitude_i > pk_mag_q) begin
                        pk_mag_d = read_magnitude_i;
                        pk_x_d   = rx_q;
                        pk_y_d   = ry_q;
                    end
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (sink.out_ready) begin
                    valid_d = 1'b0;
                    if (eof_q) begin
                        state_d = ST_DONE;
                    end else begin
                        if (rx_q == X_LAST) begin
                            rx_d = '0;
                            ry_d = ry_q + YW'(1);
                        end else begin
                            rx_d = rx_q + XW'(1);
                        end
                        wait_d  = LAT_LD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign read_x_o       = rx_q;
    assign read_y_o       = ry_q;
    assign sink.out_valid = valid_q;
    assign sink.out_x     = ox_q;
    assign sink.out_y     = oy_q;
    assign sink.out_psi   = psi_q;
    assign sink.out_mag   = mag_q;
    assign sink.out_sof   = sof_q;
    assign sink.out_eol   = eol_q;
    assign sink.out_eof   = eof_q;
    assign hold_evolve_o  = (state_q != ST_IDLE);
    assign norm_valid_o   = (state_q == ST_DONE);
    assign norm_sum_o     = sum_q;
    assign peak_mag_o     = pk_mag_q;
    assign peak_x_o       = pk_x_q;
    assign peak_y_o       = pk_y_q;
    assign overrun_cnt_o  = ovr_q;
endmodule

// File: tb/tb_wave_field_streamer.sv
// Bench for wave_field_streamer: two instances (READ_LAT 1 and 3) share one mesh image and stimulus,
// and a frame-level model predicts every output on every cycle.
module tb_wave_field_streamer;
    localparam int MX = 8;
    localparam int MY = 8;
    localparam int PW = 16;
    localparam int XW = 3;
    localparam int YW = 3;
    localparam int SW = PW + XW + YW;
    localparam int NS = MX * MY;

    logic clk = 1'b0;
    logic rst;
    logic fd;
    logic [7:0] decim;
    logic rdy;
    always #5 clk = ~clk;

    logic [2*PW-1:0] mem_psi [NS];
    logic [PW-1:0]   mem_mag [NS];

    logic [XW-1:0]   rx [2];
    logic [YW-1:0]   ry [2];
    logic [2*PW-1:0] rpsi [2];
    logic [PW-1:0]   rmag [2];
    logic            hold [2];
    logic            nv [2];
    logic [SW-1:0]   nsum [2];
    logic [PW-1:0]   pmag [2];
    logic [XW-1:0]   px [2];
    logic [YW-1:0]   py [2];
    logic [7:0]      ovr [2];
    logic            ov [2];
    logic [XW-1:0]   ox [2];
    logic [YW-1:0]   oy [2];
    logic [2*PW-1:0] opsi [2];
    logic [PW-1:0]   omag [2];
    logic            osof [2];
    logic            oeol [2];
    logic            oeof [2];

    wave_field_streamer_if #(.MESH_X(MX), .MESH_Y(MY), .PSI_WIDTH(PW)) sif0 ();
    wave_field_streamer_if #(.MESH_X(MX), .MESH_Y(MY), .PSI_WIDTH(PW)) sif1 ();
    assign sif0.out_ready = rdy;
    assign sif1.out_ready = rdy;
    assign ov[0] = sif0.out_valid;  assign ov[1] = sif1.out_valid;
    assign ox[0] = sif0.out_x;      assign ox[1] = sif1.out_x;
    assign oy[0] = sif0.out_y;      assign oy[1] = sif1.out_y;
    assign opsi[0] = sif0.out_psi;  assign opsi[1] = sif1.out_psi;
    assign omag[0] = sif0.out_mag;  assign omag[1] = sif1.out_mag;
    assign osof[0] = sif0.out_sof;  assign osof[1] = sif1.out_sof;
    assign oeol[0] = sif0.out_eol;  assign oeol[1] = sif1.out_eol;
    assign oeof[0] = sif0.out_eof;  assign oeof[1] = sif1.out_eof;

    wave_field_streamer #(.MESH_X(MX), .MESH_Y(MY), .PSI_WIDTH(PW), .READ_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .frame_done_i(fd), .decim_i(decim),
        .read_x_o(rx[0]), .read_y_o(ry[0]), .read_psi_i(rpsi[0]), .read_magnitude_i(rmag[0]),
        .sink(sif0), .hold_evolve_o(hold[0]), .norm_valid_o(nv[0]), .norm_sum_o(nsum[0]),
        .peak_mag_o(pmag[0]), .peak_x_o(px[0]), .peak_y_o(py[0]), .overrun_cnt_o(ovr[0])
    );
    wave_field_streamer #(.MESH_X(MX), .MESH_Y(MY), .PSI_WIDTH(PW), .READ_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .frame_done_i(fd), .decim_i(decim),
        .read_x_o(rx[1]), .read_y_o(ry[1]), .read_psi_i(rpsi[1]), .read_magnitude_i(rmag[1]),
        .sink(sif1), .hold_evolve_o(hold[1]), .norm_valid_o(nv[1]), .norm_sum_o(nsum[1]),
        .peak_mag_o(pmag[1]), .peak_x_o(px[1]), .peak_y_o(py[1]), .overrun_cnt_o(ovr[1])
    );

    // Mesh read port: data for an address is readable READ_LAT-1 registered cycles after it settles.
    int ai0, ai1, ai1_d1, ai1_d2;
    assign ai0 = int'({ry[0], rx[0]});
    assign ai1 = int'({ry[1], rx[1]});
    always @(posedge clk) begin
        ai1_d1 <= ai1;
        ai1_d2 <= ai1_d1;
    end
    assign rpsi[0] = mem_psi[ai0];
    assign rmag[0] = mem_mag[ai0];
    assign rpsi[1] = mem_psi[ai1_d2];
    assign rmag[1] = mem_mag[ai1_d2];

    int n_chk, n_pass, cyc;
    int LAT [2] = '{1, 3};

    bit     scanning [2], done [2];
    int     k [2], wt [2], dcnt [2], ovr_m [2], ax [2], ay [2];
    longint acc [2], fin_sum [2];
    int     pk [2], pkx [2], pky [2], fin_pk [2], fin_px [2], fin_py [2];
    int     nv_cnt [2], hs_cnt [2], sof_c [2], eol_c [2], eof_c [2];

    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, i, act, exp, cyc);
    endtask

    // Called at the falling edge: compare what the DUTs show now, then predict the next rising edge.
    task automatic model_cycle();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                chk("rst_valid", i, ov[i], 0);     chk("rst_sof", i, osof[i], 0);
                chk("rst_eol", i, oeol[i], 0);     chk("rst_eof", i, oeof[i], 0);
                chk("rst_norm_valid", i, nv[i], 0); chk("rst_hold", i, hold[i], 0);
                chk("rst_read_x", i, rx[i], 0);    chk("rst_read_y", i, ry[i], 0);
                chk("rst_out_x", i, ox[i], 0);     chk("rst_out_y", i, oy[i], 0);
                chk("rst_out_psi", i, opsi[i], 0); chk("rst_out_mag", i, omag[i], 0);
                chk("rst_norm_sum", i, nsum[i], 0); chk("rst_peak_mag", i, pmag[i], 0);
                chk("rst_peak_x", i, px[i], 0);    chk("rst_peak_y", i, py[i], 0);
                chk("rst_overrun", i, ovr[i], 0);
                scanning[i] = 0; done[i] = 0; k[i] = 0; wt[i] = 0; dcnt[i] = 0; ovr_m[i] = 0;
                ax[i] = 0; ay[i] = 0; fin_sum[i] = 0; fin_pk[i] = 0; fin_px[i] = 0; fin_py[i] = 0;
            end else begin
                bit ev;
                ev = scanning[i] && (wt[i] >= LAT[i]);
                chk("out_valid", i, ov[i], ev);
                chk("hold_evolve", i, hold[i], scanning[i] || done[i]);
                chk("norm_valid", i, nv[i], done[i]);
                chk("read_x", i, rx[i], ax[i]);
                chk("read_y", i, ry[i], ay[i]);
                chk("overrun_cnt", i, ovr[i], ovr_m[i]);
                if (ev && ov[i]) begin
                    chk("out_x", i, ox[i], k[i] % MX);
                    chk("out_y", i, oy[i], k[i] / MX);
                    chk("out_psi", i, opsi[i], mem_psi[k[i]]);
                    chk("out_mag", i, omag[i], mem_mag[k[i]]);
                    chk("out_sof", i, osof[i], k[i] == 0);
                    chk("out_eol", i, oeol[i], (k[i] % MX) == MX - 1);
                    chk("out_eof", i, oeof[i], k[i] == NS - 1);
                end
                if (!scanning[i]) begin
                    chk("norm_sum", i, nsum[i], fin_sum[i]);
                    chk("peak_mag", i, pmag[i], fin_pk[i]);
                    chk("peak_x", i, px[i], fin_px[i]);
                    chk("peak_y", i, py[i], fin_py[i]);
                end
                if (nv[i]) nv_cnt[i]++;

                if (done[i]) begin
                    done[i] = 0;
                    if (fd && ovr_m[i] < 255) ovr_m[i]++;
                end else if (scanning[i]) begin
                    if (fd && ovr_m[i] < 255) ovr_m[i]++;
                    if (ev && rdy) begin
                        hs_cnt[i]++;
                        sof_c[i] += int'(osof[i]); eol_c[i] += int'(oeol[i]); eof_c[i] += int'(oeof[i]);
                        acc[i] += longint'(mem_mag[k[i]]);
                        if (int'(mem_mag[k[i]]) > pk[i]) begin
                            pk[i] = int'(mem_mag[k[i]]); pkx[i] = k[i] % MX; pky[i] = k[i] / MX;
                        end
                        if (k[i] == NS - 1) begin
                            scanning[i] = 0; done[i] = 1;
                            fin_sum[i] = acc[i]; fin_pk[i] = pk[i]; fin_px[i] = pkx[i]; fin_py[i] = pky[i];
                        end else begin
                            k[i]++; ax[i] = k[i] % MX; ay[i] = k[i] / MX; wt[i] = 0;
                        end
                    end else begin
                        wt[i]++;
                    end
                end else if (fd) begin
                    if (dcnt[i] == 0) begin
                        dcnt[i] = int'(decim); scanning[i] = 1; k[i] = 0; wt[i] = 0;
                        ax[i] = 0; ay[i] = 0; acc[i] = 0; pk[i] = 0; pkx[i] = 0; pky[i] = 0;
                    end else begin
                        dcnt[i]--;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((hold[0] || hold[1]) && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", 0, longint'(hold[0] || hold[1]), 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic load_ramp();
        for (int j = 0; j < NS; j++) begin
            mem_psi[j] = {16'(j), 16'(-j)};
            mem_mag[j] = 16'(j);
        end
    endtask

    task automatic load_rand(input int maxmag);
        for (int j = 0; j < NS; j++) begin
            mem_psi[j] = $urandom;
            mem_mag[j] = 16'($urandom_range(0, maxmag));
        end
    endtask

    initial begin
        int c0, fv0, fv1, nvt, s_hs, s_sof, s_eol, s_eof, s_nv0, s_nv1, r1, r2, n;
        bit pv;
        n_chk = 0; n_pass = 0; cyc = 0;
        rst = 1'b1; fd = 1'b0; decim = 8'd0; rdy = 1'b1;
        load_ramp();
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Ramp frame with the sink always ready
        s_hs = hs_cnt[0]; s_sof = sof_c[0]; s_eol = eol_c[0]; s_eof = eof_c[0];
        fd = 1'b1; c0 = cyc; fv0 = -1; fv1 = -1; nvt = -1;
        for (int m = 0; m < 400 && nvt < 0; m++) begin
            step();
            fd = 1'b0;
            if (fv0 < 0 && ov[0]) fv0 = cyc - c0;
            if (fv1 < 0 && ov[1]) fv1 = cyc - c0;
            if (nv[0]) nvt = cyc - c0;
        end
        chk("first_valid_lat1", 0, fv0, 2);
        chk("first_valid_lat3", 1, fv1, 4);
        chk("norm_valid_time", 0, nvt, 129);
        wait_idle(1000);
        chk("ramp_norm_sum", 0, nsum[0], 2016);
        chk("ramp_norm_sum", 1, nsum[1], 2016);
        chk("ramp_peak_mag", 0, pmag[0], 63);
        chk("ramp_peak_x", 0, px[0], 7);
        chk("ramp_peak_y", 0, py[0], 7);
        chk("ramp_samples", 0, hs_cnt[0] - s_hs, 64);
        chk("ramp_sof_count", 0, sof_c[0] - s_sof, 1);
        chk("ramp_eol_count", 0, eol_c[0] - s_eol, 8);
        chk("ramp_eof_count", 0, eof_c[0] - s_eof, 1);

        // Same frame under random backpressure
        s_hs = hs_cnt[1];
        fd = 1'b1;
        step();
        fd = 1'b0;
        n = 0;
        while ((hold[0] || hold[1]) && n < 5000) begin
            rdy = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        rdy = 1'b1;
        chk("bp_timeout", 0, longint'(hold[0] || hold[1]), 0);
        chk("bp_norm_sum", 0, nsum[0], 2016);
        chk("bp_samples", 1, hs_cnt[1] - s_hs, 64);

        // Decimation by 3
        pulse_rst();
        decim = 8'd2;
        s_nv0 = nv_cnt[0];
        for (int f = 0; f < 9; f++) begin
            fd = 1'b1;
            step();
            fd = 1'b0;
            repeat (199) step();
        end
        wait_idle(1000);
        decim = 8'd0;
        chk("decim_frames", 0, nv_cnt[0] - s_nv0, 3);
        chk("decim_overrun", 0, ovr[0], 0);

        // Overrun during the scan and during DONE
        pulse_rst();
        load_rand(65535);
        fd = 1'b1;
        step();
        fd = 1'b0;
        repeat (30) step();
        fd = 1'b1;
        step();
        fd = 1'b0;
        n = 0;
        while (!nv[0] && n < 400) begin
            step();
            n++;
        end
        chk("done_reached", 0, nv[0], 1);
        fd = 1'b1;
        step();
        fd = 1'b0;
        wait_idle(1000);
        chk("overrun_two", 0, ovr[0], 2);
        chk("overrun_two", 1, ovr[1], 2);

        // Overrun saturation
        pulse_rst();
        rdy = 1'b0;
        fd = 1'b1;
        repeat (301) step();
        fd = 1'b0;
        step();
        chk("overrun_sat", 0, ovr[0], 255);
        chk("overrun_sat", 1, ovr[1], 255);
        rdy = 1'b1;
        wait_idle(1000);

        // Tied peak: the first in scan order wins
        pulse_rst();
        load_rand(16'h7FFE);
        mem_mag[1*MX + 2] = 16'h7FFF;
        mem_mag[6*MX + 5] = 16'h7FFF;
        fd = 1'b1;
        step();
        fd = 1'b0;
        r1 = -1; r2 = -1; pv = 1'b0; n = 0;
        while ((hold[0] || hold[1]) && n < 1000) begin
            step();
            n++;
            if (ov[1] && !pv) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            pv = ov[1];
        end
        chk("tie_timeout", 0, longint'(hold[0] || hold[1]), 0);
        chk("sample_spacing_lat3", 1, r2 - r1, 4);
        for (int i = 0; i < 2; i++) begin
            chk("tie_peak_mag", i, pmag[i], 16'h7FFF);
            chk("tie_peak_x", i, px[i], 2);
            chk("tie_peak_y", i, py[i], 1);
        end

        // Reset in the middle of a scan
        load_rand(65535);
        s_hs = hs_cnt[0];
        fd = 1'b1;
        step();
        fd = 1'b0;
        n = 0;
        while (hs_cnt[0] - s_hs < 20 && n < 500) begin
            step();
            n++;
        end
        chk("reach_sample20", 0, hs_cnt[0] - s_hs, 20);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 0, ov[0], 0);
        chk("async_rst_hold", 0, hold[0], 0);
        chk("async_rst_read_y", 0, ry[0], 0);
        chk("async_rst_hold", 1, hold[1], 0);
        step();
        rst = 1'b0;
        s_nv0 = nv_cnt[0]; s_nv1 = nv_cnt[1];
        repeat (300) step();
        chk("no_partial_norm", 0, nv_cnt[0] - s_nv0, 0);
        chk("no_partial_norm", 1, nv_cnt[1] - s_nv1, 0);
        s_hs = hs_cnt[0];
        fd = 1'b1;
        step();
        fd = 1'b0;
        wait_idle(1000);
        chk("restart_samples", 0, hs_cnt[0] - s_hs, 64);
        chk("restart_norm", 0, nv_cnt[0] - s_nv0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
